imem_dmem_arbiter: RTL
======================

// Module: imem_dmem_arbiter
// PURPOSE
//   Shares one single-ported synchronous memory between the fetch stage (instruction reads)
//   and the memory stage (data loads/stores). Arbitrates per cycle, issues the granted
//   request to memory, and routes read data back to the owner after a fixed latency.
//   Drives the fetch stall input whenever an instruction request is not granted.
// PARAMETERS
//   AW         32  address width (byte address; low 2 bits passed through unchanged)
//   MEM_LAT    1   memory read latency in cycles, 1..4 (request cycle -> mem_rdata valid)
//   STARVE_MAX 3   consecutive denied fetch cycles after which fetch gets priority, 1..15
// PORTS
//   clk         in   1   clock
//   rst_n       in   1   reset, asynchronous, active-low
//   if_req_i    in   1   fetch requests an instruction read
//   if_addr_i   in   AW  fetch address (PC)
//   if_gnt_o    out  1   fetch request issued to memory this cycle
//   if_rvalid_o out  1   if_rdata_o valid
//   if_rdata_o  out  32  instruction word
//   if_stall_o  out  1   if_req_i & ~if_gnt_o; drives fetch stall_i
//   dm_req_i    in   1   memory stage requests an access
//   dm_we_i     in   1   1 = store, 0 = load
//   dm_addr_i   in   AW  data address
//   dm_wdata_i  in   32  store data
//   dm_be_i     in   4   store byte enables
//   dm_gnt_o    out  1   data request issued to memory this cycle
//   dm_rvalid_o out  1   dm_rdata_o valid (loads only)
//   dm_rdata_o  out  32  load data
//   mem_req_o   out  1   memory access strobe
//   mem_we_o    out  1   memory write enable
//   mem_addr_o  out  AW  memory address
//   mem_wdata_o out  32  memory write data
//   mem_be_o    out  4   memory byte enables (4'hF for reads)
//   mem_rdata_i in   32  memory read data, valid MEM_LAT cycles after read request
// BEHAVIOUR
//   - Reset: all outputs 0; state PRIO_DATA; starve counter 0; response tag pipe cleared.
//   - Memory always accepts; at most one grant per cycle; grants combinational from reqs+state.
//   - FSM PRIO_DATA: both requesting -> data wins. Only one requesting -> it wins.
//     Starve counter increments each cycle if_req_i & ~if_gnt_o, clears on if_gnt_o or ~if_req_i.
//     Counter reaching STARVE_MAX -> next state PRIO_FETCH.
//   - FSM PRIO_FETCH: both requesting -> fetch wins; after any fetch grant -> PRIO_DATA,
//     counter cleared. If fetch drops request, return to PRIO_DATA, counter cleared.
//   - mem_*_o mirror the granted requester combinationally; mem_req_o = if_gnt_o | dm_gnt_o.
//     Instruction reads: mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
//   - Tag pipe: MEM_LAT-deep shift reg of {valid, owner}; entered on every read grant
//     (stores enter valid=0). Tail valid -> assert matching *_rvalid_o and load *_rdata_o
//     from mem_rdata_i for one cycle. rdata outputs hold last value otherwise.
//   - Back-to-back reads supported: one response per cycle, strictly in issue order.
//   - Requesters hold req/addr/data until granted; changing them while ungranted is legal
//     (arbiter is stateless w.r.t. request contents).
//   - Stores: single-cycle, no response.
//   - Reset mid-operation: in-flight tags discarded, no rvalid pulses after reset deasserts.
// STRUCTURE
//   - Shared pkg (cpu_pkg): typedef enum logic {OWN_FETCH, OWN_DATA} mem_owner_e;
//     typedef enum logic {PRIO_DATA, PRIO_FETCH} arb_state_e; typedef struct packed
//     {logic valid; mem_owner_e owner;} mem_tag_t.
//   - One sub-module: mem_resp_tracker (MEM_LAT tag shift register + response routing).
// TESTING
//   1. Fetch alone, addr 0x0,0x4,0x8 consecutive, MEM_LAT=1 -> if_gnt_o=1 each cycle,
//      if_rvalid_o 1 cycle later with words in order, if_stall_o=0.
//   2. Both request, dm load 0x100 for 2 cycles -> dm_gnt_o both cycles, if_stall_o=1,
//      fetch granted cycle 3, dm_rvalid_o then if_rvalid_o with correct data.
//   3. Data requests continuously, STARVE_MAX=3 -> fetch granted exactly on 4th cycle
//      of contention, data granted next cycle, pattern repeats every 4 cycles.
//   4. Store 0xDEADBEEF be=4'b0011 to 0x200 -> mem_we_o=1, mem_be_o=4'b0011, no rvalid;
//      following load 0x200 returns merged data.
//   5. MEM_LAT=3, alternating fetch/load grants -> rvalids arrive 3 cycles after grant,
//      one per cycle, routed to correct owner.
//   6. Assert rst_n low with 2 reads in flight -> all outputs 0, no rvalid after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the fetch/data memory arbiter: owner tags, arbitration
// priority state and the in-flight response tag.
package cpu_pkg;

  typedef enum logic {OWN_FETCH, OWN_DATA} mem_owner_e;
  typedef enum logic {PRIO_DATA, PRIO_FETCH} arb_state_e;

  typedef struct packed {
    logic       valid;
    mem_owner_e owner;
  } mem_tag_t;

  localparam logic [3:0] BE_ALL = 4'hF;

endpackage

// File: rtl/mem_resp_tracker.sv
// Tracks outstanding reads through the fixed-latency memory and steers each
// returning word to the requester that issued it, strictly in issue order.
module mem_resp_tracker
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  mem_owner_e  owner_i,
  input  logic [31:0] mem_rdata_i,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        dm_rvalid_o,
  output logic [31:0] dm_rdata_o
);

  mem_tag_t [MEM_LAT-1:0] tag_q;
  mem_tag_t [MEM_LAT:0]   shifted;
  mem_tag_t               push_tag;
  mem_tag_t               tail;
  logic [31:0]            if_rdata_q;
  logic [31:0]            dm_rdata_q;

  // Stores still shift an invalid tag so every slot ages by exactly one cycle.
  assign push_tag = '{valid: push_i, owner: owner_i};
  assign shifted  = {tag_q, push_tag};
  assign tail     = tag_q[MEM_LAT-1];

  assign if_rvalid_o = tail.valid && (tail.owner == OWN_FETCH);
  assign dm_rvalid_o = tail.valid && (tail.owner == OWN_DATA);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : if_rdata_q;
  assign dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : dm_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q      <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      tag_q <= shifted[MEM_LAT-1:0];
      if (if_rvalid_o) if_rdata_q <= mem_rdata_i;
      if (dm_rvalid_o) dm_rdata_q <= mem_rdata_i;
    end
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Per-cycle arbiter sharing one single-ported memory between instruction
// fetch and the data stage; data wins by default, fetch after starvation.
module imem_dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [31:0]   if_rdata_o,
  output logic          if_stall_o,
  input  logic          dm_req_i,
  input  logic          dm_we_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [31:0]   dm_wdata_i,
  input  logic [3:0]    dm_be_i,
  output logic          dm_gnt_o,
  output logic          dm_rvalid_o,
  output logic [31:0]   dm_rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
  output logic [3:0]    mem_be_o,
  input  logic [31:0]   mem_rdata_i
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_e state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       store;
  mem_owner_e push_owner;

  // Grants are held low during reset so every output reads zero.
  always_comb begin
    if_gnt_o = 1'b0;
    dm_gnt_o = 1'b0;
    if (rst_n) begin
      if (state_q == PRIO_FETCH) begin
        if_gnt_o = if_req_i;
        dm_gnt_o = dm_req_i & ~if_req_i;
      end else begin
        dm_gnt_o = dm_req_i;
        if_gnt_o = if_req_i & ~dm_req_i;
      end
    end
  end

  // Leaving PRIO_FETCH always clears the count: fetch was either granted or dropped.
  always_comb begin
    starve_d = '0;
    state_d  = PRIO_DATA;
    if (state_q == PRIO_DATA && if_req_i && !if_gnt_o) begin
      starve_d = starve_q + 4'd1;
      if (starve_d == STARVE_LIM) state_d = PRIO_FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= PRIO_DATA;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  assign store       = dm_gnt_o & dm_we_i;
  assign if_stall_o  = rst_n & if_req_i & ~if_gnt_o;
  assign mem_req_o   = if_gnt_o | dm_gnt_o;
  assign mem_we_o    = store;
  assign mem_addr_o  = if_gnt_o ? if_addr_i : (dm_gnt_o ? dm_addr_i : '0);
  assign mem_wdata_o = store ? dm_wdata_i : '0;
  assign mem_be_o    = store ? dm_be_i : (mem_req_o ? BE_ALL : '0);
  assign push_owner  = if_gnt_o ? OWN_FETCH : OWN_DATA;

  mem_resp_tracker #(
    .MEM_LAT (MEM_LAT)
  ) u_resp (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (mem_req_o & ~mem_we_o),
    .owner_i     (push_owner),
    .mem_rdata_i (mem_rdata_i),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .dm_rvalid_o (dm_rvalid_o),
    .dm_rdata_o  (dm_rdata_o)
  );

endmodule
